// File: rtl/algo_1w1r_pbank_resp_if.sv
// Port bundle for the banked 1W1R responder: per-bank write port A, read port B,
// plus init/ready and sticky error status.
interface algo_1w1r_pbank_resp_if #(
   parameter int NUMVBNK = 8,
   parameter int BITSROW = 10,
   parameter int PHYWDTH = 64
);
   localparam int BNKW = (NUMVBNK > 1) ? $clog2(NUMVBNK) : 1;

   // Handshake: writeA[b]/readB[b] are single-cycle strobes sampled at posedge clk and
   // are accepted only while ready is high; there is no backpressure once ready rises.
   logic                         ready;
   logic [NUMVBNK-1:0]           writeA;
   logic [NUMVBNK*BITSROW-1:0]   addrA;
   logic [NUMVBNK*PHYWDTH-1:0]   dinA;
   logic [NUMVBNK*PHYWDTH-1:0]   bwA;
   logic [NUMVBNK-1:0]           readB;
   logic [NUMVBNK*BITSROW-1:0]   addrB;
   logic [NUMVBNK*PHYWDTH-1:0]   doutB;
   logic                         err;
   logic [BNKW-1:0]              err_bnk;

   modport master (
      input  ready, doutB, err, err_bnk,
      output writeA, addrA, dinA, bwA, readB, addrB
   );

   modport slave (
      output ready, doutB, err, err_bnk,
      input  writeA, addrA, dinA, bwA, readB, addrB
   );
endinterface

// File: rtl/algo_1w1r_pbank_resp.sv
// Banked 1W1R memory responder: self-initialises every row after reset, then serves
// one bit-masked write and one fixed-latency read per bank per cycle, flagging misuse.
module algo_1w1r_pbank_resp #(
   parameter int                 NUMVBNK = 8,
   parameter int                 NUMSROW = 1024,
   parameter int                 BITSROW = 10,
   parameter int                 PHYWDTH = 64,
   parameter int                 DELAY   = 1,
   parameter logic [PHYWDTH-1:0] INITVAL = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   algo_1w1r_pbank_resp_if.slave       bus,
   output logic [0:0]                  stateDbg
);
   localparam int BNKW = (NUMVBNK > 1) ? $clog2(NUMVBNK) : 1;
   localparam int IDXW = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;
   localparam logic [BITSROW:0] ROWLIM = (BITSROW+1)'(NUMSROW);

   typedef enum logic {INIT, READY} state_t;

   state_t                     state;
   state_t                     stateNext;
   logic [IDXW-1:0]            initCnt;
   logic                       isReady;
   logic [NUMVBNK-1:0]         errHit;
   logic [BNKW-1:0]            firstBnk;
   logic                       err;
   logic [BNKW-1:0]            errBnk;
   logic [NUMVBNK*PHYWDTH-1:0] doutAll;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= INIT;
         initCnt <= '0;
      end else begin
         state <= stateNext;
         if (state == INIT) initCnt <= initCnt + IDXW'(1);
      end
   end

   always_comb begin
      stateNext = state;
      if (state == INIT && initCnt == IDXW'(NUMSROW - 1)) stateNext = READY;
   end

   assign isReady  = (state == READY);
   assign stateDbg = state;

   for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
      logic [BITSROW-1:0] rowA;
      logic [BITSROW-1:0] rowB;
      logic               wrInRange;
      logic               rdInRange;
      logic [PHYWDTH-1:0] dinA;
      logic [PHYWDTH-1:0] bwA;
      logic [PHYWDTH-1:0] rdData;
      logic [PHYWDTH-1:0] doutQ;
      logic [PHYWDTH-1:0] memArr [NUMSROW];
      logic [DELAY-1:0]   pipeVld;
      logic [PHYWDTH-1:0] pipeData [DELAY];

      assign rowA      = bus.addrA[b*BITSROW +: BITSROW];
      assign rowB      = bus.addrB[b*BITSROW +: BITSROW];
      assign dinA      = bus.dinA[b*PHYWDTH +: PHYWDTH];
      assign bwA       = bus.bwA[b*PHYWDTH +: PHYWDTH];
      assign wrInRange = ({1'b0, rowA} < ROWLIM);
      assign rdInRange = ({1'b0, rowB} < ROWLIM);
      // Out-of-range reads still occupy a pipe slot so the caller sees a response.
      assign rdData    = rdInRange ? memArr[rowB[IDXW-1:0]] : '0;

      assign errHit[b] = isReady ?
                         ((bus.writeA[b] & ~wrInRange) | (bus.readB[b] & ~rdInRange)) :
                         (bus.writeA[b] | bus.readB[b]);

      always_ff @(posedge clk) begin
         if (rst) begin
            if (state == INIT) begin
               memArr[initCnt] <= INITVAL;
            end else if (bus.writeA[b] && wrInRange) begin
               memArr[rowA[IDXW-1:0]] <= (memArr[rowA[IDXW-1:0]] & ~bwA) | (dinA & bwA);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            pipeVld <= '0;
            doutQ   <= '0;
            for (int d = 0; d < DELAY; d++) pipeData[d] <= '0;
         end else begin
            pipeVld[0]  <= isReady & bus.readB[b];
            pipeData[0] <= rdData;
            for (int d = 1; d < DELAY; d++) begin
               pipeVld[d]  <= pipeVld[d-1];
               pipeData[d] <= pipeData[d-1];
            end
            if (pipeVld[DELAY-1]) doutQ <= pipeData[DELAY-1];
         end
      end

      assign doutAll[b*PHYWDTH +: PHYWDTH] = doutQ;
   end

   always_comb begin
      firstBnk = '0;
      for (int b = NUMVBNK - 1; b >= 0; b--) begin
         if (errHit[b]) firstBnk = BNKW'(b);
      end
   end

   // err_bnk latches only the first offending cycle; later errors keep err high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err    <= 1'b0;
         errBnk <= '0;
      end else if (|errHit) begin
         err <= 1'b1;
         if (!err) errBnk <= firstBnk;
      end
   end

   assign bus.ready   = isReady;
   assign bus.doutB   = doutAll;
   assign bus.err     = err;
   assign bus.err_bnk = errBnk;
endmodule

// File: tb/tb_algo_1w1r_pbank_resp.sv
// Bench for algo_1w1r_pbank_resp: directed vectors plus a behavioural memory model
// compared against the DUT on every cycle after the first reset edge.
module tb_algo_1w1r_pbank_resp;
   localparam int NB = 8;
   localparam int NR = 1024;
   localparam int BR = 11;
   localparam int PW = 64;
   localparam int DL = 3;
   localparam logic [PW-1:0] IV = 64'h0123_4567_89AB_CDEF;
   localparam int EW = 32 + 8 + PW;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] stateDbg;

   algo_1w1r_pbank_resp_if #(.NUMVBNK(NB), .BITSROW(BR), .PHYWDTH(PW)) bus ();

   algo_1w1r_pbank_resp #(
      .NUMVBNK(NB), .NUMSROW(NR), .BITSROW(BR), .PHYWDTH(PW), .DELAY(DL), .INITVAL(IV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .stateDbg(stateDbg)
   );

   // clock/reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string name, input logic [NB*PW-1:0] act,
                            input logic [NB*PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] dout(input int b);
      return bus.doutB[b*PW +: PW];
   endfunction

   // behavioural model / scoreboard
   logic [PW-1:0]    mMem [NB][NR];
   logic             mReady = 1'b0;
   logic             mErr = 1'b0;
   logic [2:0]       mErrBnk = '0;
   logic [NB*PW-1:0] expDout = '0;
   int               mInit = 0;
   int               cyc = 0;
   logic             chkEn = 1'b0;
   logic [EW-1:0]    exp_q[$];

   always @(posedge clk) begin : model_p
      logic [NB-1:0] hit;
      logic          rdy;
      int            ra;
      int            rb;
      logic [EW-1:0] e;
      logic [PW-1:0] d;
      cyc++;
      if (!rst) begin
         mReady  = 1'b0;
         mInit   = 0;
         mErr    = 1'b0;
         mErrBnk = '0;
         expDout = '0;
         exp_q.delete();
         chkEn   = 1'b1;
      end else begin
         rdy = mReady;
         while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e = exp_q.pop_front();
            expDout[int'(e[PW+7:PW])*PW +: PW] = e[PW-1:0];
         end
         hit = '0;
         for (int b = 0; b < NB; b++) begin
            ra = int'(bus.addrA[b*BR +: BR]);
            rb = int'(bus.addrB[b*BR +: BR]);
            if (!rdy) hit[b] = bus.writeA[b] | bus.readB[b];
            else      hit[b] = (bus.writeA[b] && ra >= NR) || (bus.readB[b] && rb >= NR);
         end
         if (hit != '0) begin
            if (!mErr) begin
               for (int b = NB - 1; b >= 0; b--) if (hit[b]) mErrBnk = 3'(b);
            end
            mErr = 1'b1;
         end
         for (int b = 0; b < NB; b++) begin
            if (rdy && bus.readB[b]) begin
               rb = int'(bus.addrB[b*BR +: BR]);
               if (rb < NR) d = mMem[b][rb];
               else         d = '0;
               exp_q.push_back({32'(cyc + DL), 8'(b), d});
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (rdy && bus.writeA[b]) begin
               ra = int'(bus.addrA[b*BR +: BR]);
               if (ra < NR) mMem[b][ra] = (mMem[b][ra] & ~bus.bwA[b*PW +: PW]) |
                                          (bus.dinA[b*PW +: PW] & bus.bwA[b*PW +: PW]);
            end
         end
         if (!rdy) begin
            mInit++;
            if (mInit == NR) begin
               mReady = 1'b1;
               for (int b = 0; b < NB; b++)
                  for (int r = 0; r < NR; r++) mMem[b][r] = IV;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         check_val("ready", bus.ready, mReady);
         check_val("err", bus.err, mErr);
         check_val("err_bnk", bus.err_bnk, mErrBnk);
         check_val("doutB", bus.doutB, expDout);
      end
   end

   // driver tasks: always entered and left at a negedge
   task automatic clear_ports();
      bus.writeA = '0;
      bus.readB  = '0;
      bus.addrA  = '0;
      bus.addrB  = '0;
      bus.dinA   = '0;
      bus.bwA    = '0;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
      clear_ports();
   endtask

   task automatic set_write(input int b, input int row, input logic [PW-1:0] d,
                            input logic [PW-1:0] bw);
      bus.writeA[b]          = 1'b1;
      bus.addrA[b*BR +: BR]  = BR'(row);
      bus.dinA[b*PW +: PW]   = d;
      bus.bwA[b*PW +: PW]    = bw;
   endtask

   task automatic set_read(input int b, input int row);
      bus.readB[b]          = 1'b1;
      bus.addrB[b*BR +: BR] = BR'(row);
   endtask

   task automatic wait_ready(input string name, input int injAt, input int wb, input int rb);
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 2000) begin
         if (n == injAt) begin
            if (wb >= 0) set_write(wb, 0, '1, '1);
            if (rb >= 0) set_read(rb, 0);
         end
         tick();
         n++;
      end
      check_val(name, n, NR);
   endtask

   initial begin
      clear_ports();
      rst = 1'b0;
      tick(3);
      rst = 1'b1;

      // init timing, with a write to bank 6 row 0 after init has passed that row
      wait_ready("init_cycles", 4, 6, -1);
      check_val("err_init_write", bus.err, 1'b1);
      check_val("err_bnk_init", bus.err_bnk, 3'd6);
      set_read(3, 1023);
      set_read(6, 0);
      tick(1 + DL);
      check_val("b3_r1023_initval", dout(3), IV);
      check_val("b6_r0_untouched", dout(6), IV);

      // bit-masked write
      set_write(0, 5, '1, '1);
      tick();
      set_write(0, 5, '0, 64'h00FF);
      tick();
      set_read(0, 5);
      tick(1 + DL);
      check_val("bitwrite", dout(0), 64'hFFFF_FFFF_FFFF_FF00);

      // read during write returns old data
      set_write(2, 7, 64'hA5, '1);
      tick();
      set_write(2, 7, 64'h5A, '1);
      set_read(2, 7);
      tick(1 + DL);
      check_val("rdw_old", dout(2), 64'hA5);
      set_read(2, 7);
      tick(1 + DL);
      check_val("rdw_new", dout(2), 64'h5A);

      // latency and hold
      set_write(1, 9, 64'hDEAD_BEEF_0000_1111, '1);
      tick();
      set_read(1, 9);
      tick();
      tick(DL - 1);
      check_val("lat_early", dout(1), 64'h0);
      tick();
      check_val("lat_at", dout(1), 64'hDEAD_BEEF_0000_1111);
      for (int i = 4; i <= 10; i++) begin
         tick();
         check_val("lat_hold", dout(1), 64'hDEAD_BEEF_0000_1111);
      end
      check_val("other_b0", dout(0), 64'hFFFF_FFFF_FFFF_FF00);
      check_val("other_b2", dout(2), 64'h5A);

      // out-of-range accesses
      set_read(4, 2);
      tick(1 + DL);
      check_val("b4_inrange", dout(4), IV);
      set_read(4, 1024);
      set_write(5, 1500, '0, '1);
      tick(1 + DL);
      check_val("oob_read_zero", dout(4), 64'h0);
      check_val("err_bnk_kept", bus.err_bnk, 3'd6);
      set_read(5, 476);
      tick(1 + DL);
      check_val("oob_write_dropped", dout(5), IV);

      // reset with two reads in flight
      set_read(0, 5);
      tick();
      set_read(2, 7);
      tick();
      rst = 1'b0;
      tick();
      check_val("rst_dout", bus.doutB, '0);
      check_val("rst_ready", bus.ready, 1'b0);
      check_val("rst_err", bus.err, 1'b0);
      rst = 1'b1;
      wait_ready("reinit_cycles", 10, 2, 5);
      check_val("err_bnk_lowest", bus.err_bnk, 3'd2);
      set_read(0, 5);
      tick(1 + DL);
      check_val("reinit_row", dout(0), IV);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
